// File: rtl/change_dispenser.sv
// Coin-change payout controller driving a hopper one coin at a time.
// Ports: clk, rst, goods_out, change[1:0], hopper_coin, clr_fault -> hopper_en, busy, done, fault, overrun, total_paid[7:0].
module change_dispenser #(
  parameter int TIMEOUT   = 16,
  parameter int GAP_CYC   = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goods_out,
  input  logic [1:0] change,
  input  logic       hopper_coin,
  input  logic       clr_fault,
  output logic       hopper_en,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overrun,
  output logic [7:0] total_paid
);

  typedef enum logic [2:0] {
    IDLE,
    EJECT,
    WAIT_ACK,
    GAP,
    FAULT
  } state_t;

  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] G_LAST = 4'(GAP_CYC - 1);
  localparam logic [2:0] R_MAX  = 3'(MAX_RETRY);

  state_t     state, state_nx;
  logic [1:0] rem, rem_nx;
  logic [2:0] retry, retry_nx;
  logic [7:0] timer, timer_nx;
  logic [3:0] gap_cnt, gap_nx;
  logic       pend_v, pend_v_nx;
  logic [1:0] pend_c, pend_c_nx;
  logic [7:0] paid_nx;
  logic       done_nx, ovr_nx;
  logic       req;

  assign req = goods_out && (change != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      retry      <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      pend_v     <= 1'b0;
      pend_c     <= '0;
      total_paid <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      rem        <= rem_nx;
      retry      <= retry_nx;
      timer      <= timer_nx;
      gap_cnt    <= gap_nx;
      pend_v     <= pend_v_nx;
      pend_c     <= pend_c_nx;
      total_paid <= paid_nx;
      done       <= done_nx;
      overrun    <= ovr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem;
    retry_nx  = retry;
    timer_nx  = timer;
    gap_nx    = gap_cnt;
    pend_v_nx = pend_v;
    pend_c_nx = pend_c;
    paid_nx   = total_paid;
    done_nx   = 1'b0;
    ovr_nx    = overrun & ~clr_fault;

    // A request during payout goes to the one-deep slot; a full slot
    // (even one about to be drained this cycle) drops it.
    if (req && (state == EJECT || state == WAIT_ACK || state == GAP)) begin
      if (pend_v) begin
        ovr_nx = 1'b1;
      end else begin
        pend_v_nx = 1'b1;
        pend_c_nx = change;
      end
    end

    unique case (state)
      IDLE: begin
        if (req) begin
          rem_nx   = change;
          retry_nx = '0;
          state_nx = EJECT;
        end
      end
      EJECT: begin
        timer_nx = '0;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (hopper_coin) begin
          paid_nx  = total_paid + 8'd1;
          retry_nx = '0;
          timer_nx = '0;
          if (rem == 2'd1) begin
            done_nx = 1'b1;
            if (pend_v) begin
              rem_nx    = pend_c;
              pend_v_nx = 1'b0;
              state_nx  = EJECT;
            end else if (req) begin
              // Same-cycle request is served directly, not parked.
              rem_nx    = change;
              pend_v_nx = 1'b0;
              state_nx  = EJECT;
            end else begin
              rem_nx   = '0;
              state_nx = IDLE;
            end
          end else begin
            rem_nx   = rem - 2'd1;
            gap_nx   = '0;
            state_nx = GAP;
          end
        end else if (timer == T_LAST) begin
          timer_nx = '0;
          if (retry < R_MAX) begin
            retry_nx = retry + 3'd1;
            state_nx = EJECT;
          end else begin
            rem_nx    = '0;
            retry_nx  = '0;
            pend_v_nx = 1'b0;
            state_nx  = FAULT;
          end
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == G_LAST) begin
          state_nx = EJECT;
        end else begin
          gap_nx = gap_cnt + 4'd1;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_nx = IDLE;
        end else if (req) begin
          ovr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hopper_en = (state == EJECT);
  assign fault     = (state == FAULT);
  assign busy      = (state != IDLE && state != FAULT) || pend_v;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TIMEOUT, default 16: WAIT_ACK cycles allowed per coin attempt before timeout (range 2..255).
REQ-002 Parameter GAP_CYC, default 2: idle cycles between the acknowledged coin and the next eject (range 1..15).
REQ-003 Parameter MAX_RETRY, default 2: re-eject attempts allowed per coin after the first timeout (range 0..7).
REQ-004 Clk  input  1  clock, all logic on posedge; one clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 goods_out  input  1  one-cycle vend strobe from the vending FSM.
REQ-007 change  input  2  change owed, qualified by goods_out; value = number of 0.5 coins (00=0, 01=1, 10=2, 11=3).
REQ-008 hopper_coin  input  1  coin-drop sensor pulse from the hopper, one cycle per coin.
REQ-009 clr_fault  input  1  clears fault and overrun, returns FSM to IDLE.
REQ-010 hopper_en  output  1  hopper eject command.
REQ-011 busy  output  1  payout in progress or pending request held.
REQ-012 done  output  1  one-cycle strobe, request fully paid.
REQ-013 fault  output  1  hopper failure, sticky.
REQ-014 overrun  output  1  request dropped, sticky.
REQ-015 total_paid  output  8  running count of coins confirmed, wraps 255->0.

Function
REQ-016 FSM states SHALL be IDLE, EJECT, WAIT_ACK, GAP, FAULT.
REQ-017 Request SHALL be goods_out=1 with change!=0; goods_out=1 with change=00 SHALL be ignored (no state change, no done).
REQ-018 IDLE + request in cycle N: remaining<=change, retry<=0, state EJECT in cycle N+1.
REQ-019 hopper_en SHALL be 1 exactly in cycles where state=EJECT; EJECT SHALL last one cycle, then WAIT_ACK with timer<=0.
REQ-020 hopper_coin SHALL be sampled only in WAIT_ACK; pulses in any other state SHALL be ignored.
REQ-021 WAIT_ACK + hopper_coin: remaining-1, total_paid+1, retry<=0; remaining-1 != 0 -> GAP for GAP_CYC cycles, then EJECT.
REQ-022 WAIT_ACK + hopper_coin with remaining=1: done=1 next cycle, state IDLE next cycle, unless a request is queued (REQ-026).
REQ-023 Timeout: TIMEOUT consecutive WAIT_ACK cycles with no coin; hopper_coin in the final cycle SHALL count as a coin, not a timeout.
REQ-024 Timeout with retry<MAX_RETRY: retry+1, state EJECT; timeout with retry=MAX_RETRY: state FAULT.
REQ-025 FAULT: fault=1, hopper_en=0, remaining and pending discarded, requests dropped with overrun=1; clr_fault -> IDLE, fault=0, overrun=0.
REQ-026 One-deep pending slot: request while state!=IDLE and slot empty SHALL be stored; request while slot full SHALL be dropped with overrun=1.
REQ-027 At completion (REQ-022), a stored pending request SHALL be loaded, else a request in that same cycle SHALL be loaded; state EJECT next cycle, done still pulses.
REQ-028 busy SHALL equal (state!=IDLE and state!=FAULT) or pending valid.
REQ-029 clr_fault outside FAULT SHALL only clear overrun.
REQ-030 All outputs SHALL be registered or decoded from registered state; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 at posedge: state IDLE; remaining, retry, timer, pending and total_paid to 0; hopper_en, busy, done, fault, overrun to 0.
REQ-032 rst SHALL override all inputs, including mid-payout and FAULT; no coin SHALL be counted in the reset cycle.

Verification
REQ-033 change=11 + goods_out in cycle 0; hopper_coin 2 cycles after each hopper_en -> 3 hopper_en pulses spaced by GAP; done one cycle after the 3rd coin; total_paid=3.
REQ-034 change=01 request, no hopper_coin -> hopper_en asserted 3 times, each 16 WAIT_ACK cycles apart; FAULT entered; fault=1; busy=0; clr_fault -> IDLE.
REQ-035 Timeout on the 1st attempt, coin on the retry -> total_paid=1, done=1, fault=0; retry counter resets for the next coin.
REQ-036 Request change=10 while busy, then a 3rd request -> 2nd request served right after the 1st with no IDLE cycle; 3rd dropped; overrun=1.
REQ-037 goods_out with change=00 -> no hopper_en, no done, busy=0.
REQ-038 rst asserted in WAIT_ACK with hopper_coin=1 in the same cycle -> all outputs 0, total_paid=0.
